// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES gamepad poller.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] btn_word_t;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the pad serial lines; resets to the idle-high level.
module pad_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls up to two 4021-based NES pads and publishes one 8-bit button word per pad.
//
// state  | meaning
// IDLE   | waiting for the poll timer or a poll request
// LATCH  | pad_latch high, bit 0 sampled on the last cycle
// CLK_LO | low half of a shift clock
// CLK_HI | high half of a shift clock, bit sampled on the last cycle
// DONE   | publish buffers to btns, pulse btns_valid
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int BIT_HALF    = 128,
  parameter int POLL_PERIOD = 357_954
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  poll_req,
  input  logic [NUM_PADS-1:0]   pad_data_n,
  output logic                  pad_latch,
  output logic                  pad_clk,
  output logic [NUM_PADS*8-1:0] btns,
  output logic                  btns_valid,
  output logic                  busy
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam int PW = $clog2(2 * BIT_HALF);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * BIT_HALF - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(BIT_HALF - 1);

  pad_state_t            state;
  logic [TW-1:0]         timer;
  logic [PW-1:0]         phase;
  logic [2:0]            bit_idx;
  logic [NUM_PADS-1:0]   sync_n;
  logic [NUM_PADS-1:0]   sample;
  logic                  start;
  btn_word_t             shift_buf [NUM_PADS];
  btn_word_t             shifted   [NUM_PADS];

  pad_sync #(.WIDTH(NUM_PADS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_data_n),
    .q     (sync_n)
  );

  assign sample = ~sync_n;
  assign start  = (state == IDLE) && ((timer == TIMER_LAST) || poll_req);

  // Bits arrive A first, so each new sample enters at the top and slides toward bit 0.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      shifted[p] = {sample[p], shift_buf[p][BTN_RIGHT:BTN_B]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (start || timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b0;
      busy       <= 1'b0;
      btns_valid <= 1'b0;
      btns       <= '0;
      for (int p = 0; p < NUM_PADS; p++) shift_buf[p] <= '0;
    end else begin
      btns_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            phase     <= '0;
            bit_idx   <= '0;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            for (int p = 0; p < NUM_PADS; p++) shift_buf[p] <= shifted[p];
            bit_idx   <= 3'd1;
            phase     <= '0;
            pad_latch <= 1'b0;
            state     <= CLK_LO;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_LO: begin
          if (phase == HALF_LAST) begin
            phase   <= '0;
            pad_clk <= 1'b1;
            state   <= CLK_HI;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_HI: begin
          if (phase == HALF_LAST) begin
            for (int p = 0; p < NUM_PADS; p++) shift_buf[p] <= shifted[p];
            phase   <= '0;
            pad_clk <= 1'b0;
            if (bit_idx == 3'd7) begin
              for (int p = 0; p < NUM_PADS; p++) btns[p*8 +: 8] <= shifted[p];
              busy       <= 1'b0;
              btns_valid <= 1'b1;
              state      <= DONE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              state   <= CLK_LO;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: reference model of poll timing and sampled words plus directed scenarios.
module tb_nes_pad_reader;

  localparam int BH = 4;
  localparam int P  = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        poll_req;
  logic [1:0]  pad_data_n;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] btns;
  logic        btns_valid;
  logic        busy;

  logic [7:0]  pressed [2];
  int          pk [2];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc;
  int n_rise = 0, rise_cyc = -1, n_valid = 0, valid_cyc = -1;
  logic latch_q = 1'b0;

  // reference model state: poll timer and offset from latch rise (-1 when idle)
  int          m_timer, m_off;
  logic        m_st;
  logic [7:0]  rec [2];
  logic [15:0] exp_btns;

  nes_pad_reader #(.NUM_PADS(2), .BIT_HALF(BH), .POLL_PERIOD(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .poll_req   (poll_req),
    .pad_data_n (pad_data_n),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .btns       (btns),
    .btns_valid (btns_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // pad model: latch selects bit 0, each shift clock rise advances to the next button
  always @(posedge pad_clk or posedge pad_latch) begin
    for (int p = 0; p < 2; p++) pk[p] <= pad_latch ? 0 : pk[p] + 1;
  end

  always_comb begin
    pad_data_n = 2'b11;
    for (int p = 0; p < 2; p++)
      if (pk[p] < 8) pad_data_n[p] = ~pressed[p][pk[p][2:0]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always_comb m_st = (m_off < 0) && ((m_timer == P - 1) || poll_req);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_timer  <= 0;
      m_off    <= -1;
      exp_btns <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (m_off == 2*BH*(i+1) - 3)
          for (int p = 0; p < 2; p++) rec[p][i] <= pressed[p][i];
      m_timer <= (m_st || m_timer == P - 1) ? 0 : m_timer + 1;
      if (m_st)                             m_off <= 0;
      else if (m_off >= 0 && m_off < 16*BH) m_off <= m_off + 1;
      else                                  m_off <= -1;
      if (m_off == 16*BH - 1) exp_btns <= {rec[1], rec[0]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("latch", pad_latch, (m_off >= 0 && m_off < 2*BH));
    chk("pclk", pad_clk, (m_off >= 2*BH && m_off < 16*BH && ((m_off - 2*BH) % (2*BH)) >= BH));
    chk("busy", busy, (m_off >= 0 && m_off < 16*BH));
    chk("valid", btns_valid, (m_off == 16*BH));
    chk("btns", btns, exp_btns);
  end

  always @(negedge clk) begin
    latch_q <= pad_latch;
    if (pad_latch && !latch_q) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (btns_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 2000) begin tick(); n++; end
    chk("wait_cyc_timeout", (cyc >= c), 1);
  endtask

  task automatic wait_rise(input int k);
    int n = 0;
    while (n_rise < k && n < 1000) begin @(negedge clk); #1; n++; end
    chk("wait_latch_timeout", (n_rise >= k), 1);
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    while (n_valid < k && n < 1000) begin @(negedge clk); #1; n++; end
    chk("wait_valid_timeout", (n_valid >= k), 1);
  endtask

  initial begin
    int lat, chi, crs, vat, nr0, nv0, r;
    logic pc;
    logic [15:0] vb;
    rst_n = 1'b0;
    poll_req = 1'b0;
    pressed[0] = 8'h00;
    pressed[1] = 8'h00;
    #1;
    chk("rst_latch", pad_latch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_btns", btns, 0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: disconnected pads, first automatic poll
    wait_rise(1);
    chk("t1_latch_at", rise_cyc, 200);
    lat = 0; chi = 0; crs = 0; vat = -1; pc = 1'b0; vb = 16'hFFFF;
    for (int j = 0; j <= 64; j++) begin
      if (pad_latch) lat++;
      if (pad_clk) chi++;
      if (pad_clk && !pc) crs++;
      pc = pad_clk;
      if (btns_valid) begin vat = j; vb = btns; end
      @(negedge clk); #1;
    end
    chk("t1_latch_len", lat, 8);
    chk("t1_clk_pulses", crs, 7);
    chk("t1_clk_high", chi, 28);
    chk("t1_valid_at", vat, 64);
    chk("t1_btns", vb, 16'h0000);

    // 2: A+Start on pad0, Left+Right on pad1
    pressed[0] = 8'h09;
    pressed[1] = 8'hC0;
    wait_valid(2);
    chk("t2_btns", btns, 16'hC009);

    // 3/4: requested poll at cycle 50, then requests while busy
    nr0 = n_rise; nv0 = n_valid;
    tick(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    pressed[0] = 8'hA5;
    pressed[1] = 8'h3C;
    wait_cyc(50);
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    for (int c = 55; c <= 115; c += 5) begin
      wait_cyc(c);
      poll_req = 1'b1; tick(); poll_req = 1'b0;
    end
    wait_cyc(200);
    chk("t3_req_latch_at", rise_cyc, 51);
    chk("t4_one_latch", n_rise - nr0, 1);
    chk("t4_one_valid", n_valid - nv0, 1);
    chk("t4_valid_at", valid_cyc, 115);
    chk("t3_btns", btns, 16'h3CA5);
    wait_rise(nr0 + 2);
    chk("t3_next_auto_at", rise_cyc, 251);

    // 5: reset during the high half of bit 3
    wait_cyc(280);
    chk("t5_in_clk_hi", pad_clk, 1);
    nv0 = n_valid;
    rst_n = 1'b0;
    #1;
    chk("t5_clk_async", pad_clk, 0);
    chk("t5_latch_async", pad_latch, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_btns_async", btns, 0);
    tick(); tick();
    rst_n = 1'b1;
    wait_valid(nv0 + 1);
    chk("t5_valid_at", valid_cyc, 264);
    chk("t5_btns", btns, 16'h3CA5);

    // 6: all pressed, released after bit 3 is sampled
    nr0 = n_rise;
    pressed[0] = 8'hFF;
    pressed[1] = 8'hFF;
    wait_rise(nr0 + 1);
    r = rise_cyc;
    chk("t6_latch_at", r, 400);
    wait_cyc(r + 33);
    pressed[0] = 8'h00;
    pressed[1] = 8'h00;
    nv0 = n_valid;
    wait_valid(nv0 + 1);
    chk("t6_mixed", btns, 16'h0F0F);
    wait_valid(nv0 + 2);
    chk("t6_released", btns, 16'h0000);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
